// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a one-cycle bubble between grants.
// Optional hold-timeout enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       valid,
    output logic       timeout
);

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic [IW-1:0]   win;
    logic            release_c;
    logic            expired_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    assign cnt_inc   = cnt_q + CW'(1);
    assign expired_c = (cnt_inc == CW'(MAX_HOLD));
`else
    assign expired_c = 1'b0;
`endif

    // Rotating priority search: ptr+1, ptr+2, ptr+3, then ptr itself.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = ptr_q + IW'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign release_c = done || !req[grant_id_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        timeout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    grant_d    = N'(1) << win;
                    grant_id_d = win;
                    ptr_d      = win;
`ifdef ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                // A normal release takes precedence, so timeout only flags forced drops.
                if (release_c || expired_c) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    timeout_d  = !release_c;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase
        valid_d = |grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= IW'(N - 1);
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter; expected values are hand-computed.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       valid;
    logic       timeout;

    int total;
    int bad;

    rr_arbiter #(.MAX_HOLD(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .valid    (valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic t);
        check_val({tag, ".grant"}, 32'(grant), 32'(g));
        if (v) check_val({tag, ".id"}, 32'(grant_id), 32'(id));
        check_val({tag, ".valid"}, 32'(valid), 32'(v));
        check_val({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        logic [1:0] order [5];
        total = 0;
        bad   = 0;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        req  = 4'b0000;
        done = 1'b0;
        rst  = 1'b1;
        #13;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_val("reset.id", 32'(grant_id), 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Single requester 3 wins first from reset pointer 3.
        req = 4'b1000;
        tick();
        check_out("req3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        check_out("req3_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("rr%0d", k), 4'(1) << order[k], order[k], 1'b1, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            check_out($sformatf("rr%0d_bub", k), 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        req = 4'b0000;
        tick();

        // Requester 1 holds while 0 and 3 arrive; next winner is 3.
        req = 4'b0010;
        tick();
        check_out("hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1011;
        tick();
        check_out("hold1_b", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        check_out("hold1_c", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("hold1_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("after1", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Release by dropping the granted request.
        req = 4'b0011;
        tick();
        check_out("reqdrop", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Pointer is 3, so requester 2 wins; done and req drop together release once.
        req = 4'b0100;
        tick();
        check_out("g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;
        check_out("both_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("both_rel2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant, then requester 0 favoured again.
        req = 4'b0100;
        tick();
        check_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0101;
        tick();
        check_out("in_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Long hold on requester 0 with no done.
        req = 4'b0001;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            tick();
            check_out($sformatf("hold_%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        check_out("forced_rel", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check_out("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_out($sformatf("hold_%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;
        check_out("final", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum cycles a grant is held before forced release; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request lines, one per requester; bit i is requester i.
REQ-005 done  input  1  granted requester finished with the shared resource; 1-cycle pulse.
REQ-006 grant  output  4  one-hot grant; all zero when nothing is granted.
REQ-007 grant_id  output  2  binary index of the granted requester; meaningful only while valid=1.
REQ-008 valid  output  1  high while any grant bit is set.
REQ-009 timeout  output  1  1-cycle pulse on forced release; tied 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-010 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 In IDLE with req!=0 at a rising edge, the arbiter SHALL enter BUSY at that edge and assert the grant; req-to-grant latency is 1 cycle.
REQ-012 Winner selection SHALL be round-robin: search order is ptr+1, ptr+2, ptr+3, ptr (mod 4), and the first set req bit wins.
REQ-013 ptr SHALL be loaded with the winner index on the grant edge.
REQ-014 In BUSY, grant, grant_id and valid SHALL stay constant until release; new or dropped requests from other requesters SHALL NOT affect them.
REQ-015 Release SHALL occur on the edge where done=1, or where req[grant_id]=0, whichever comes first.
REQ-016 On release, the arbiter SHALL return to IDLE, so grant=0 for exactly one cycle (bubble) before any next grant.
REQ-017 done in IDLE SHALL be ignored.
REQ-018 If done and the granted requester's req drop in the same cycle, the arbiter SHALL perform a single release.
REQ-019 grant SHALL always be one-hot or zero; grant_id SHALL equal the index of the set bit; valid SHALL equal |grant.
REQ-020 With req=4'b1111 held and done pulsed every grant, grant order from reset SHALL be 0,1,2,3,0,...

Reset
REQ-021 On rst=1, the arbiter SHALL immediately set state=IDLE, grant=0, grant_id=0, valid=0, timeout=0, ptr=3 (so requester 0 wins first) and hold count=0, without waiting for clk.
REQ-022 Reset asserted mid-grant SHALL drop the grant at once; the first post-reset arbitration SHALL again favour requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN: when defined, a hold counter SHALL clear on grant and increment each BUSY cycle.
REQ-024 The counter SHALL force release on the edge where it reaches MAX_HOLD, with timeout=1 for the following cycle.
REQ-025 A done and a timeout in the same cycle SHALL count as a normal release with timeout=0.
REQ-026 When ARB_TIMEOUT_EN is undefined, no counter SHALL exist, timeout SHALL be constant 0, and a grant SHALL be held indefinitely.

Verification
REQ-027 Reset, req=4'b0000 for 10 cycles -> grant=0, valid=0, timeout=0 throughout.
REQ-028 req=4'b1000 -> one cycle later grant=4'b1000, grant_id=2'b11, valid=1; done pulse -> grant=0 next cycle.
REQ-029 req=4'b1111, done pulsed each time valid=1 -> grant_id sequence 0,1,2,3,0, with one idle cycle between grants.
REQ-030 Grant on requester 1, then raise req[0] and req[3] while busy -> grant stays 4'b0010 until done; the next grant goes to 3, not 0.
REQ-031 Assert rst while grant=4'b0100 -> grant=0 immediately, asynchronously; after rst release with req=4'b0101, the grant goes to requester 0.
REQ-032 ARB_TIMEOUT_EN, MAX_HOLD=15, req=4'b0001 held, no done -> grant released after 15 BUSY cycles, timeout pulses once, then requester 0 is regranted after the bubble.
